// File: rtl/tone_nco_pkg.sv
// Shared types and table helpers for the tone NCO.
// Waveform encoding and quarter-wave sine table generator.
package tone_nco_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_e;

    localparam real PI = 3.14159265358979323846;

    // round(M*sin(pi*k/(2Q))), M = 2^(width-1)-1, Q = 2^lut_log2
    function automatic int qrom_init(int k, int lut_log2, int width);
        real m;
        real x;
        m = real'((1 << (width - 1)) - 1);
        x = m * $sin(PI * real'(k) / real'(2 << lut_log2));
        return $rtoi($floor(x + 0.5));
    endfunction

endpackage

// File: rtl/tone_nco_qrom.sv
// Quarter-wave sine magnitude table, Q+1 entries.
// Synchronous read, contents fixed at elaboration.
module tone_nco_qrom
    import tone_nco_pkg::*;
#(
    parameter int width_p    = 12,
    parameter int lut_log2_p = 8
) (
    input  logic                  clk_i,
    input  logic                  en,
    input  logic [lut_log2_p:0]   addr,
    output logic [width_p-2:0]    data
);

    localparam int Q = 1 << lut_log2_p;

    logic [width_p-2:0] rom [Q+1];

    for (genvar k = 0; k <= Q; k++) begin : g_rom
        assign rom[k] = (width_p - 1)'(qrom_init(k, lut_log2_p, width_p));
    end

    always_ff @(posedge clk_i) begin
        if (en) begin
            data <= rom[addr];
        end
    end

endmodule

// File: rtl/tone_nco.sv
// Tone generator: phase accumulator, waveform stage, output register.
// Sine/square/saw/triangle with shift attenuation and valid/ready output.
module tone_nco
    import tone_nco_pkg::*;
#(
    parameter int width_p       = 12,
    parameter int phase_width_p = 24,
    parameter int lut_log2_p    = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     cfg_valid_i,
    input  logic [phase_width_p-1:0] cfg_ftw_i,
    input  logic [1:0]               cfg_mode_i,
    input  logic [1:0]               cfg_amp_shift_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [width_p-1:0]       data_o
);

    localparam int W  = width_p;
    localparam int PW = phase_width_p;
    localparam int L  = lut_log2_p;
    localparam int Q  = 1 << L;

    localparam logic [W-1:0] MAX_C  = W'((1 << (W - 1)) - 1);
    localparam logic [W-1:0] HALF_C = W'(1 << (W - 1));
    localparam logic [L:0]   Q_C    = (L + 1)'(Q);

    if (PW < 12 || PW < L + 2) begin : g_bad_params
        $error("tone_nco: phase_width_p too small");
    end

    logic                 adv;
    logic [PW-1:0]        phase_r;
    logic [PW-1:0]        ftw_r;
    logic [PW-1:0]        ftw_eff;
    mode_e                mode_r;
    mode_e                mode_eff;
    logic [1:0]           amp_r;
    logic [1:0]           amp_eff;

    logic                 s1_v;
    logic [W-1:0]         s1_u;
    mode_e                s1_mode;
    logic [1:0]           s1_amp;

    logic                 qd_odd;
    logic [L-1:0]         idx;
    logic [L:0]           rom_addr;
    logic [W-2:0]         rom_q;
    logic [W-1:0]         sine_mag;
    logic [W-2:0]         tri_f;
    logic signed [W-1:0]  wave;
    logic signed [W-1:0]  shaped;

    assign adv = ~valid_o | ready_i;

    // A config written on this edge already applies to the sample taken on it
    assign ftw_eff  = cfg_valid_i ? cfg_ftw_i : ftw_r;
    assign mode_eff = cfg_valid_i ? mode_e'(cfg_mode_i) : mode_r;
    assign amp_eff  = cfg_valid_i ? cfg_amp_shift_i : amp_r;

    assign qd_odd   = phase_r[PW-2];
    assign idx      = phase_r[PW-3 -: L];
    assign rom_addr = qd_odd ? Q_C - {1'b0, idx} : {1'b0, idx};

    tone_nco_qrom #(
        .width_p    (W),
        .lut_log2_p (L)
    ) u_qrom (
        .clk_i (clk_i),
        .en    (adv),
        .addr  (rom_addr),
        .data  (rom_q)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ftw_r  <= '0;
            mode_r <= MODE_SINE;
            amp_r  <= '0;
        end else if (cfg_valid_i) begin
            ftw_r  <= cfg_ftw_i;
            mode_r <= mode_e'(cfg_mode_i);
            amp_r  <= cfg_amp_shift_i;
        end
    end

    assign sine_mag = {1'b0, rom_q};
    assign tri_f    = s1_u[W-1] ? ~s1_u[W-2:0] : s1_u[W-2:0];

    always_comb begin
        wave = '0;
        unique case (s1_mode)
            MODE_SINE:   wave = s1_u[W-1] ? -sine_mag : sine_mag;
            MODE_SQUARE: wave = s1_u[W-1] ? -MAX_C : MAX_C;
            MODE_SAW:    wave = {~s1_u[W-1], s1_u[W-2:0]};
            MODE_TRI:    wave = {tri_f, 1'b0} - HALF_C;
        endcase
    end

    assign shaped = wave >>> s1_amp;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            phase_r <= '0;
            s1_v    <= 1'b0;
            s1_u    <= '0;
            s1_mode <= MODE_SINE;
            s1_amp  <= '0;
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (adv) begin
            s1_v    <= 1'b1;
            s1_u    <= phase_r[PW-1 -: W];
            s1_mode <= mode_eff;
            s1_amp  <= amp_eff;
            phase_r <= phase_r + ftw_eff;
            valid_o <= s1_v;
            data_o  <= s1_v ? shaped : '0;
        end
    end

endmodule

// File: tb/tb_tone_nco.sv
// Directed bench for tone_nco at 12-bit samples, 24-bit phase, 256-step table.
// Checks handshake, waveforms, attenuation, retuning and reset behaviour.
module tb_tone_nco;

    localparam int W  = 12;
    localparam int PW = 24;
    localparam int L  = 8;

    logic                 clk_i           = 1'b0;
    logic                 reset_ni        = 1'b1;
    logic                 cfg_valid_i     = 1'b0;
    logic [PW-1:0]        cfg_ftw_i       = '0;
    logic [1:0]           cfg_mode_i      = '0;
    logic [1:0]           cfg_amp_shift_i = '0;
    logic                 ready_i         = 1'b0;
    logic                 valid_o;
    logic signed [W-1:0]  data_o;

    int nvec = 0;
    int nerr = 0;

    logic [PW-1:0] m_phase;
    logic [PW-1:0] m_ftw;
    logic [PW-1:0] m_ftw2;
    int            m_sw;
    int            m_cnt;
    int            m_mode;
    int            m_amp;
    int            smp[$];
    int            held;
    int            mx;
    int            mn;

    always #5 clk_i = ~clk_i;

    tone_nco #(
        .width_p       (W),
        .phase_width_p (PW),
        .lut_log2_p    (L)
    ) dut (
        .clk_i           (clk_i),
        .reset_ni        (reset_ni),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_ftw_i       (cfg_ftw_i),
        .cfg_mode_i      (cfg_mode_i),
        .cfg_amp_shift_i (cfg_amp_shift_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .data_o          (data_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_sample(logic [PW-1:0] ph, int mode, int amp);
        logic [9:0]  q;
        logic [11:0] u;
        logic [10:0] f;
        int k;
        int r;
        int v;
        q = ph[23:14];
        u = ph[23:12];
        case (mode)
            0: begin
                k = q[8] ? 256 - int'(q[7:0]) : int'(q[7:0]);
                r = $rtoi($floor(2047.0 * $sin(3.141592653589793 * k / 512.0) + 0.5));
                v = q[9] ? -r : r;
            end
            1: v = ph[23] ? -2047 : 2047;
            2: v = int'(u) - 2048;
            default: begin
                f = u[11] ? ~u[10:0] : u[10:0];
                v = 2 * int'(f) - 2048;
            end
        endcase
        return v >>> amp;
    endfunction

    task automatic step();
        if (valid_o && ready_i) begin
            check($sformatf("smp%0d", m_cnt), data_o,
                  exp_sample(m_phase, m_mode, m_amp));
            smp.push_back(data_o);
            m_phase = m_phase + ((m_cnt >= m_sw) ? m_ftw2 : m_ftw);
            m_cnt++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic stream(input int n, input bit rnd);
        for (int c = 0; c < n; c++) begin
            ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
    endtask

    task automatic restart(input logic [PW-1:0] ftw, input int mode, input int amp);
        #2 reset_ni = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        cfg_valid_i     = 1'b1;
        cfg_ftw_i       = ftw;
        cfg_mode_i      = 2'(mode);
        cfg_amp_shift_i = 2'(amp);
        ready_i         = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cfg_valid_i = 1'b0;
        check("edge1_valid", valid_o, 0);
        @(posedge clk_i);
        #1;
        check("edge2_valid", valid_o, 1);
        check("first_sample", data_o, exp_sample('0, mode, amp));
        m_phase = '0;
        m_ftw   = ftw;
        m_ftw2  = ftw;
        m_sw    = 1 << 30;
        m_cnt   = 0;
        m_mode  = mode;
        m_amp   = amp;
        smp.delete();
    endtask

    initial begin
        restart(24'h040000, 0, 0);
        stream(82, 1'b0);
        check("sin_n0", smp[0], 0);
        check("sin_n4", smp[4], 783);
        check("sin_n8", smp[8], 1447);
        check("sin_n16", smp[16], 2047);
        check("sin_n32", smp[32], 0);
        check("sin_n48", smp[48], -2047);
        check("sin_n64", smp[64], 0);
        check("sin_n80", smp[80], 2047);

        ready_i = 1'b0;
        held    = data_o;
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_data", data_o, held);
            check("hold_valid", valid_o, 1);
        end
        stream(40, 1'b0);
        stream(60, 1'b1);

        restart(24'h040000, 0, 0);
        ready_i     = 1'b1;
        cfg_valid_i = 1'b1;
        cfg_ftw_i   = 24'h080000;
        m_ftw2      = 24'h080000;
        m_sw        = 2;
        step();
        cfg_valid_i = 1'b0;
        stream(20, 1'b0);
        check("ftw_n2", smp[2], 399);
        check("ftw_n3", smp[3], 783);
        check("ftw_n5", smp[5], 1447);
        check("ftw_n9", smp[9], 2047);

        restart(24'h100000, 1, 0);
        stream(34, 1'b0);
        check("sq_n7", smp[7], 2047);
        check("sq_n8", smp[8], -2047);
        check("sq_n15", smp[15], -2047);
        check("sq_n16", smp[16], 2047);

        restart(24'h040000, 0, 2);
        stream(66, 1'b0);
        mx = -9999;
        mn = 9999;
        foreach (smp[j]) begin
            if (smp[j] > mx) mx = smp[j];
            if (smp[j] < mn) mn = smp[j];
        end
        check("amp_peak", mx, 511);
        check("amp_trough", mn, -512);

        restart(24'h030000, 2, 1);
        stream(30, 1'b1);
        check("saw_first", smp[0], -1024);

        restart(24'h050000, 3, 0);
        stream(30, 1'b1);
        check("tri_first", smp[0], -2048);

        restart(24'h000000, 1, 0);
        stream(20, 1'b1);
        check("dc_last", smp[smp.size() - 1], 2047);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/tone_nco.md
TONE_NCO -- requirements
Module: tone_nco

Interface
REQ-001 SHALL have parameter width_p, default 12, signed sample width of data_o.
REQ-002 SHALL have parameter phase_width_p, default 24, phase accumulator width; legal range is 12 or more, and at least lut_log2_p+2.
REQ-003 SHALL have parameter lut_log2_p, default 8, log2 of quarter-wave table resolution (Q = 2^lut_log2_p).
REQ-004 SHALL have port clk_i, input, 1 bit, the single clock; all state is rising-edge.
REQ-005 SHALL have port reset_ni, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 SHALL have port cfg_valid_i, input, 1 bit, which loads the cfg_* inputs into configuration registers.
REQ-007 SHALL have port cfg_ftw_i, input, phase_width_p bits, the frequency tuning word (phase increment per sample).
REQ-008 SHALL have port cfg_mode_i, input, 2 bits, the waveform: 0 sine, 1 square, 2 saw, 3 triangle.
REQ-009 SHALL have port cfg_amp_shift_i, input, 2 bits, an arithmetic right-shift attenuation of 0..3.
REQ-010 SHALL have port ready_i, input, 1 bit, consumer ready.
REQ-011 SHALL have port valid_o, output, 1 bit, meaning data_o holds a sample.
REQ-012 SHALL have port data_o, output, width_p bits, signed two's-complement sample.

Function
REQ-013 SHALL define the condition adv = ~valid_o | ready_i; the whole pipeline advances only on adv.
REQ-014 SHALL use a 2-stage pipeline: stage 1 (table lookup plus waveform select, with valid bit s1_v) and an output register (valid_o).
REQ-015 SHALL, on adv: capture phase_r, ftw_r and mode_r into stage 1, set s1_v=1, update phase_r to phase_r+ftw_r modulo 2^phase_width_p, and load the output register from stage 1 with valid_o<=s1_v.
REQ-016 SHALL emit samples in phase order 0, F, 2F, ... with no sample dropped or duplicated under any ready_i pattern.
REQ-017 SHALL hold data_o and valid_o stable while valid_o=1 and ready_i=0, with phase_r frozen.
REQ-018 SHALL make the first valid_o=1 appear on the 2nd rising edge after reset_ni deasserts, independent of ready_i.
REQ-019 SHALL write ftw_r, mode_r and amp_r on any edge where cfg_valid_i=1, regardless of handshake state.
REQ-020 SHALL make a new ftw_r govern the first phase increment at or after the load edge.
REQ-021 SHALL pipeline mode and amp_shift with each sample so that every sample uses a single consistent configuration.
REQ-022 SHALL define the table top index as q = phase bits [phase_width_p-1 -: lut_log2_p+2] (2-bit quadrant qd, L-bit index i), and u = the top width_p bits of the phase.
REQ-023 SHALL compute the sine by quadrant: qd0 = +rom[i], qd1 = +rom[Q-i], qd2 = -rom[i], qd3 = -rom[Q-i].
REQ-024 SHALL define rom[k] = round(M*sin(pi*k/(2Q))) for k = 0..Q (Q+1 entries), with M = 2^(width_p-1)-1.
REQ-025 SHALL output square as +M when the phase MSB is 0 and -M otherwise.
REQ-026 SHALL output saw as u with its MSB inverted, interpreted signed (range -2^(width_p-1) .. 2^(width_p-1)-1).
REQ-027 SHALL compute triangle as f = (MSB ? ~u[width_p-2:0] : u[width_p-2:0]), output {f,1'b0} - 2^(width_p-1).
REQ-028 SHALL compute the output as (stage-1 value) >>> amp_shift, arithmetic, with no rounding.
REQ-029 SHALL let phase wraparound be silent modulo 2^phase_width_p, and SHALL treat ftw=0 as a constant (DC) output, still handshaked.

Reset
REQ-030 SHALL, while reset_ni=0, asynchronously clear phase_r, s1_v, valid_o, data_o, ftw_r, mode_r (sine) and amp_r to 0.
REQ-031 SHALL, on reset asserted mid-stream, abandon in-flight samples; after release, output restarts at phase 0.

Structure
REQ-032 SHALL place the mode enum (sine/square/saw/tri) and a rounding ROM-init function in package tone_nco_pkg.
REQ-033 SHALL implement the quarter-wave table as sub-module tone_nco_qrom: synchronous read, Q+1 entries, initialised at elaboration.
REQ-034 SHALL NOT use multipliers in the datapath; attenuation is by shift only.

Verification (width_p=12, phase_width_p=24, lut_log2_p=8, M=2047)
REQ-035 SHALL cover: sine, ftw=0x040000, ready_i=1 -> valid_o rises on edge 2; samples n=0,16,32,48 = 0, +2047, 0, -2047; period 64.
REQ-036 SHALL cover: ready_i low for 5 cycles mid-stream -> data_o held; the resumed sequence is contiguous (no skip, no repeat).
REQ-037 SHALL cover: square, ftw=0x100000 -> repeating 8 x +2047 then 8 x -2047.
REQ-038 SHALL cover: sine with amp_shift=2 -> peak +511, trough -512.
REQ-039 SHALL cover: ftw changed 0x040000 -> 0x080000 mid-stream -> step size doubles from the next increment, with the pre-change samples unaltered.
REQ-040 SHALL cover: reset_ni pulsed low asynchronously mid-stream -> valid_o=0 and data_o=0 immediately; the first post-reset sample is 0.
